// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial pattern detector.
//   PAT_MIN / PAT_MAX : legal range of the pattern length
//   MODE_OVL / MODE_NOVL : values of the OVERLAP parameter
//   clog2()           : ceiling log2, used to size the fill counter
package seq_pkg;

    localparam int PAT_MIN   = 2;
    localparam int PAT_MAX   = 16;
    localparam int MODE_OVL  = 1;
    localparam int MODE_NOVL = 0;

    // Ceiling log2; clog2(1)=0, clog2(5)=3.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 <<< k) < value) begin
                res = k + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter with clear priority.
// Ports:
//   c    in   clock, rising edge
//   rst  in   synchronous reset, active high
//   inc  in   count one detection on this edge
//   clr  in   synchronous clear; a coincident inc still counts (result 1)
//   cnt  out  CNT_W-bit registered count, sticks at all-ones
//   sat  out  sticky flag, set when cnt reaches all-ones
module seq_hit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             sat_nxt_s;

    // Next count: clear first, then the coincident hit is applied on top.
    always_comb begin
        cnt_nxt_s = cnt_r;
        sat_nxt_s = sat_r;
        if (clr) begin
            cnt_nxt_s = inc ? CNT_ONE : CNT_ZERO;
            sat_nxt_s = inc && (CNT_ONE == CNT_MAX);
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            sat_nxt_s = sat_r | ((cnt_r + CNT_ONE) == CNT_MAX);
        end else begin
            cnt_nxt_s = cnt_r;
            sat_nxt_s = sat_r;
        end
    end

    // Count and saturation registers.
    always_ff @(posedge c) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            sat_r <= sat_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign sat = sat_r;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector.
// Ports:
//   c        in   clock, rising edge
//   rst      in   synchronous reset, active high; clears history, fill, out, counter
//   i        in   serial data bit, consumed only when en=1
//   en       in   sample enable
//   clr_cnt  in   synchronous clear of hit_cnt/sat (history untouched)
//   out      out  registered one-cycle detection strobe
//   hit_cnt  out  saturating detection count
//   sat      out  sticky saturation flag
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic             i,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             sat
);

    generate
        if ((PAT_LEN < PAT_MIN) || (PAT_LEN > PAT_MAX)) begin : g_bad_len
            $error("seq_detect_param: PAT_LEN must be within 2..16");
        end
    endgenerate

    localparam int                FILL_W    = clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    logic [PAT_LEN-1:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    logic               out_r;
    logic [PAT_LEN-1:0] nxt_s;
    logic [FILL_W-1:0]  fill_nxt_s;
    logic               match_s;

    // Candidate history and match decision for the bit being sampled now.
    // The fill test guarantees PAT_LEN real bits, so all-zero patterns cannot
    // match on the reset contents of the history.
    always_comb begin
        nxt_s      = {hist_r[PAT_LEN-2:0], i};
        fill_nxt_s = (fill_r == FILL_FULL) ? FILL_FULL : (fill_r + FILL_ONE);
        if (en) begin
            match_s = (fill_nxt_s == FILL_FULL) && (nxt_s == PATTERN);
        end else begin
            match_s = 1'b0;
        end
    end

    // History, fill and strobe registers. In non-overlap mode a hit restarts
    // the fill count while the history still shifts in the new bit.
    always_ff @(posedge c) begin
        if (rst) begin
            hist_r <= {PAT_LEN{1'b0}};
            fill_r <= FILL_ZERO;
            out_r  <= 1'b0;
        end else begin
            if (en) begin
                hist_r <= nxt_s;
                fill_r <= (match_s && (OVERLAP == MODE_NOVL)) ? FILL_ZERO : fill_nxt_s;
            end else begin
                hist_r <= hist_r;
                fill_r <= fill_r;
            end
            out_r <= match_s;
        end
    end

    assign out = out_r;

    seq_hit_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .c  (c),
        .rst(rst),
        .inc(match_s),
        .clr(clr_cnt),
        .cnt(hit_cnt),
        .sat(sat)
    );

endmodule
